wordle_guess_engine: RTL and testbench

Parametrised guess-entry and scoring engine for the Wordle design; successor to the fixed six-guess state machine. Clocked by the divided system clock and driven by the debounced Start/Ack pulse and the U/D/L/R/C button pulses. Holds the letter-by-letter guess being edited. Scores each submitted guess against a target word with correct duplicate-letter handling, and counts guesses up to a configurable limit. Exposes per-letter colour results and one-hot state outputs for LED and VGA logic.

---
 rtl/wordle_guess_engine.sv | 156 +++++++++++++++
 tb/tb_wordle_guess_engine.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wordle_guess_engine.sv
// Wordle guess-entry and scoring engine: button-driven letter editing, two-pass
// duplicate-aware scoring against a latched target, and a guess-limited game FSM.
module wordle_guess_engine #(
    parameter int WORD_LEN  = 5,
    parameter int MAX_GUESS = 6
) (
    input  logic                          Clk,
    input  logic                          reset,
    input  logic                          Start,
    input  logic                          Ack,
    input  logic                          U,
    input  logic                          D,
    input  logic                          L,
    input  logic                          R,
    input  logic                          C,
    input  logic [5*WORD_LEN-1:0]         target,
    output logic [5*WORD_LEN-1:0]         cur_guess,
    output logic [$clog2(WORD_LEN)-1:0]   cursor,
    output logic [3:0]                    guess_num,
    output logic [2*WORD_LEN-1:0]         result,
    output logic                          result_valid,
    output logic                          win,
    output logic                          q_I,
    output logic                          q_Entry,
    output logic                          q_Score,
    output logic                          q_Done
);

    localparam int CW = $clog2(WORD_LEN);
    localparam int HW = $clog2(WORD_LEN + 1);
    localparam int SW = $clog2(2 * WORD_LEN + 1);
    localparam logic [CW-1:0] LAST = CW'(WORD_LEN - 1);

    typedef enum logic [1:0] {S_INIT, S_ENTRY, S_SCORE, S_DONE} state_t;
    state_t state, state_nxt;

    logic [5*WORD_LEN-1:0] tgt;
    logic [HW-1:0]         hist [26];
    logic [WORD_LEN-1:0]   green;
    logic [2*WORD_LEN-1:0] res_work;
    logic [SW-1:0]         step;

    logic          pass1, pass2, fin;
    logic [CW-1:0] idx;
    logic [4:0]    g_let, t_let, e_let;
    logic [3:0]    gnum_inc;
    logic          all_green, last_guess;

    // step 0..W-1 is pass 1, W..2W-1 is pass 2, 2W publishes the score
    assign pass1      = step < SW'(WORD_LEN);
    assign pass2      = !pass1 && (step < SW'(2 * WORD_LEN));
    assign fin        = step == SW'(2 * WORD_LEN);
    assign idx        = pass1 ? CW'(step) : CW'(step - SW'(WORD_LEN));
    assign g_let      = cur_guess[5*idx +: 5];
    assign t_let      = tgt[5*idx +: 5];
    assign e_let      = cur_guess[5*cursor +: 5];
    assign gnum_inc   = guess_num + 4'd1;
    assign all_green  = &green;
    assign last_guess = gnum_inc == 4'(MAX_GUESS);

    assign q_I     = state == S_INIT;
    assign q_Entry = state == S_ENTRY;
    assign q_Score = state == S_SCORE;
    assign q_Done  = state == S_DONE;

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) state <= S_INIT;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT:  if (Start) state_nxt = S_ENTRY;
            S_ENTRY: if (C) state_nxt = S_SCORE;
            S_SCORE: if (fin) state_nxt = (all_green || last_guess) ? S_DONE : S_ENTRY;
            S_DONE:  if (Ack) state_nxt = S_INIT;
            default: state_nxt = S_INIT;
        endcase
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            tgt          <= '0;
            cur_guess    <= '0;
            cursor       <= '0;
            guess_num    <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            win          <= 1'b0;
            green        <= '0;
            res_work     <= '0;
            step         <= '0;
            for (int k = 0; k < 26; k++) hist[k] <= '0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                S_INIT: begin
                    if (Start) begin
                        tgt       <= target;
                        cur_guess <= '0;
                        cursor    <= '0;
                        guess_num <= '0;
                        result    <= '0;
                        win       <= 1'b0;
                    end
                end
                S_ENTRY: begin
                    if (C) begin
                        step     <= '0;
                        green    <= '0;
                        res_work <= '0;
                        for (int k = 0; k < 26; k++) hist[k] <= '0;
                    end else if (U) begin
                        cur_guess[5*cursor +: 5] <= (e_let == 5'd25) ? 5'd0 : e_let + 5'd1;
                    end else if (D) begin
                        cur_guess[5*cursor +: 5] <= (e_let == 5'd0) ? 5'd25 : e_let - 5'd1;
                    end else if (L) begin
                        if (cursor != '0) cursor <= cursor - 1'b1;
                    end else if (R) begin
                        if (cursor != LAST) cursor <= cursor + 1'b1;
                    end
                end
                S_SCORE: begin
                    step <= step + 1'b1;
                    if (pass1) begin
                        if (g_let == t_let) begin
                            green[idx]         <= 1'b1;
                            res_work[2*idx +: 2] <= 2'b10;
                        end else if (t_let < 5'd26) begin
                            hist[t_let] <= hist[t_let] + 1'b1;
                        end
                    end else if (pass2) begin
                        // gray is the cleared default, so only yellow needs writing
                        if (!green[idx] && g_let < 5'd26 && hist[g_let] != '0) begin
                            res_work[2*idx +: 2] <= 2'b01;
                            hist[g_let]          <= hist[g_let] - 1'b1;
                        end
                    end else if (fin) begin
                        result       <= res_work;
                        result_valid <= 1'b1;
                        guess_num    <= gnum_inc;
                        if (all_green) begin
                            win <= 1'b1;
                        end else if (!last_guess) begin
                            cur_guess <= '0;
                            cursor    <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wordle_guess_engine.sv
// Self-checking bench for wordle_guess_engine: directed cases plus randomized games
// compared against a letter-counting reference model of Wordle scoring.
module tb_wordle_guess_engine;

    localparam int W   = 5;
    localparam int MG  = 6;
    localparam int W4  = 4;
    localparam int MG4 = 3;

    logic Clk = 1'b0;
    logic reset = 1'b1;
    logic Start = 1'b0, Ack = 1'b0, U = 1'b0, D = 1'b0, L = 1'b0, R = 1'b0, C = 1'b0;
    logic [5*W-1:0] target = '0;
    logic [5*W-1:0] cur_guess;
    logic [2:0]     cursor;
    logic [3:0]     guess_num;
    logic [2*W-1:0] result;
    logic           result_valid, win, q_I, q_Entry, q_Score, q_Done;

    logic Start4 = 1'b0, Ack4 = 1'b0, C4 = 1'b0, idle4 = 1'b0;
    logic [5*W4-1:0] target4 = '0;
    logic [5*W4-1:0] cur_guess4;
    logic [1:0]      cursor4;
    logic [3:0]      guess_num4;
    logic [2*W4-1:0] result4;
    logic            result_valid4, win4, q_I4, q_Entry4, q_Score4, q_Done4;

    wordle_guess_engine #(.WORD_LEN(W), .MAX_GUESS(MG)) dut (
        .Clk(Clk), .reset(reset), .Start(Start), .Ack(Ack),
        .U(U), .D(D), .L(L), .R(R), .C(C), .target(target),
        .cur_guess(cur_guess), .cursor(cursor), .guess_num(guess_num),
        .result(result), .result_valid(result_valid), .win(win),
        .q_I(q_I), .q_Entry(q_Entry), .q_Score(q_Score), .q_Done(q_Done)
    );

    wordle_guess_engine #(.WORD_LEN(W4), .MAX_GUESS(MG4)) dut4 (
        .Clk(Clk), .reset(reset), .Start(Start4), .Ack(Ack4),
        .U(idle4), .D(idle4), .L(idle4), .R(idle4), .C(C4), .target(target4),
        .cur_guess(cur_guess4), .cursor(cursor4), .guess_num(guess_num4),
        .result(result4), .result_valid(result_valid4), .win(win4),
        .q_I(q_I4), .q_Entry(q_Entry4), .q_Score(q_Score4), .q_Done(q_Done4)
    );

    always #5 Clk = ~Clk;

    int vectors = 0;
    int miscompares = 0;

    int          m_guess[8];
    int          m_tgt[8];
    int          m_cursor;
    int          m_gnum;
    logic [15:0] m_result;
    logic        m_win;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [63:0] pack(input int len, input int w[8]);
        logic [63:0] p = '0;
        for (int i = 0; i < len; i++) p[5*i +: 5] = 5'(w[i]);
        return p;
    endfunction

    // Wordle rule: greens first; the unmatched target letters form a pool that
    // non-green guess letters draw from left to right to become yellow.
    function automatic logic [15:0] ref_score(input int len, input int g[8], input int t[8]);
        int pool[26];
        bit is_green[8];
        logic [15:0] r = '0;
        for (int k = 0; k < 26; k++) pool[k] = 0;
        for (int i = 0; i < len; i++) begin
            is_green[i] = (g[i] == t[i]);
            if (is_green[i]) r[2*i +: 2] = 2'b10;
            else pool[t[i]] += 1;
        end
        for (int i = 0; i < len; i++) begin
            if (!is_green[i] && pool[g[i]] > 0) begin
                r[2*i +: 2] = 2'b01;
                pool[g[i]] -= 1;
            end
        end
        return r;
    endfunction

    function automatic bit all_green(input int len, input logic [15:0] r);
        for (int i = 0; i < len; i++) if (r[2*i +: 2] != 2'b10) return 1'b0;
        return 1'b1;
    endfunction

    task automatic rand_word(output int w[8]);
        for (int i = 0; i < 8; i++) w[i] = $urandom_range(25, 0);
    endtask

    task automatic rand_miss(output int w[8]);
        bit same = 1'b1;
        rand_word(w);
        for (int i = 0; i < W; i++) if (w[i] != m_tgt[i]) same = 1'b0;
        if (same) w[0] = (w[0] + 1) % 26;
    endtask

    task automatic chk_state(input string tag, input logic [3:0] exp);
        chk(tag, {q_I, q_Entry, q_Score, q_Done}, exp);
    endtask

    // one ENTRY cycle with the given buttons; model follows priority C > U > D > L > R
    task automatic press(input bit u, input bit d, input bit l, input bit r, input bit c);
        U = u; D = d; L = l; R = r; C = c;
        tick();
        U = 0; D = 0; L = 0; R = 0; C = 0;
        if (c) ;
        else if (u) m_guess[m_cursor] = (m_guess[m_cursor] + 1) % 26;
        else if (d) m_guess[m_cursor] = (m_guess[m_cursor] + 25) % 26;
        else if (l) begin if (m_cursor > 0) m_cursor--; end
        else if (r) begin if (m_cursor < W - 1) m_cursor++; end
        chk("cur_guess", cur_guess, pack(W, m_guess));
        chk("cursor", cursor, m_cursor);
    endtask

    task automatic enter_word(input int w[8]);
        for (int i = 0; i < W; i++) begin
            while (m_cursor < i) press(0, 0, 0, 1, 0);
            while (m_cursor > i) press(0, 0, 1, 0, 0);
            begin
                int diff = (w[i] - m_guess[i] + 26) % 26;
                if (diff <= 13) for (int k = 0; k < diff; k++) press(1, 0, 0, 0, 0);
                else for (int k = 0; k < 26 - diff; k++) press(0, 1, 0, 0, 0);
            end
        end
    endtask

    task automatic start_game(input int w[8]);
        for (int i = 0; i < 8; i++) begin m_tgt[i] = w[i]; m_guess[i] = 0; end
        m_cursor = 0; m_gnum = 0; m_result = '0; m_win = 1'b0;
        target = pack(W, w);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        chk_state("start_state", 4'b0100);
        chk("start_guess_num", guess_num, 0);
        chk("start_result", result, 0);
        chk("start_win", win, 0);
    endtask

    task automatic submit(input bit also_u);
        int lat = 0;
        press(also_u, 0, 0, 0, 1);
        chk_state("score_state", 4'b0010);
        for (int n = 1; n <= 40 && lat == 0; n++) begin
            tick();
            if (result_valid) lat = n;
        end
        chk("latency", lat, 2 * W + 1);
        m_result = ref_score(W, m_guess, m_tgt);
        m_gnum++;
        m_win = all_green(W, m_result);
        chk("result", result, m_result[2*W-1:0]);
        chk("guess_num", guess_num, m_gnum);
        chk("win", win, m_win);
        if (m_win || m_gnum == MG) begin
            chk_state("after_score_done", 4'b0001);
        end else begin
            chk_state("after_score_entry", 4'b0100);
            for (int i = 0; i < 8; i++) m_guess[i] = 0;
            m_cursor = 0;
            chk("cleared_guess", cur_guess, 0);
            chk("cleared_cursor", cursor, 0);
        end
        tick();
        chk("rv_one_pulse", result_valid, 0);
    endtask

    task automatic ack_game();
        Ack = 1'b1;
        tick();
        Ack = 1'b0;
        chk_state("ack_init", 4'b1000);
    endtask

    task automatic submit4(input int t4[8], input int exp_gnum);
        int lat = 0;
        int z[8];
        logic [15:0] r;
        for (int i = 0; i < 8; i++) z[i] = 0;
        C4 = 1'b1;
        tick();
        C4 = 1'b0;
        for (int n = 1; n <= 40 && lat == 0; n++) begin
            tick();
            if (result_valid4) lat = n;
        end
        chk("latency4", lat, 2 * W4 + 1);
        r = ref_score(W4, z, t4);
        chk("result4", result4, r[2*W4-1:0]);
        chk("guess_num4", guess_num4, exp_gnum);
    endtask

    initial begin
        int crane[8] = '{2, 17, 0, 13, 4, 0, 0, 0};
        int apple[8] = '{0, 15, 15, 11, 4, 0, 0, 0};
        int papal[8] = '{15, 0, 15, 0, 11, 0, 0, 0};
        int w[8];
        int t4[8];
        bit saw_rv;

        // reset values
        tick(); tick();
        chk_state("reset_state", 4'b1000);
        chk("reset_guess", cur_guess, 0);
        chk("reset_cursor", cursor, 0);
        chk("reset_gnum", guess_num, 0);
        chk("reset_result", result, 0);
        chk("reset_rv", result_valid, 0);
        chk("reset_win", win, 0);
        chk("reset4", {q_I4, cur_guess4, cursor4, win4}, {1'b1, 20'd0, 2'd0, 1'b0});
        reset = 1'b0;
        tick();

        // INIT ignores buttons and Ack
        U = 1; C = 1; Ack = 1;
        tick();
        U = 0; C = 0; Ack = 0;
        chk_state("init_ignores", 4'b1000);
        chk("init_ignores_guess", cur_guess, 0);

        // exact-match win
        start_game(crane);
        enter_word(crane);
        submit(1'b0);
        chk("crane_result", result, 10'b1010101010);
        ack_game();
        chk("init_holds_win", win, 1);
        chk("init_holds_result", result, 10'b1010101010);

        // duplicate-letter handling
        start_game(apple);
        enter_word(papal);
        submit(1'b0);
        chk("papal_result", result, 10'b0100100101);

        // wraps and cursor saturation
        press(0, 1, 0, 0, 0);
        chk("d_wraps_to_z", cur_guess[4:0], 25);
        press(1, 0, 0, 0, 0);
        chk("u_wraps_to_a", cur_guess[4:0], 0);
        press(0, 0, 1, 0, 0);
        chk("l_saturates", cursor, 0);
        for (int k = 0; k < 5; k++) press(0, 0, 0, 1, 0);
        chk("r_saturates", cursor, 4);
        press(0, 0, 1, 1, 0);
        chk("l_beats_r", cursor, 3);

        // U together with C submits the unchanged letter
        rand_miss(w);
        enter_word(w);
        submit(1'b1);

        while (m_gnum < MG) begin
            rand_miss(w);
            enter_word(w);
            submit(1'b0);
        end
        chk("loss_gnum", guess_num, 6);
        chk("loss_win", win, 0);

        // DONE ignores buttons and Start
        C = 1; tick(); C = 0;
        U = 1; tick(); U = 0;
        Start = 1; target = '1; tick(); Start = 0;
        chk_state("done_holds", 4'b0001);
        chk("done_gnum", guess_num, 6);
        chk("done_result", result, m_result[2*W-1:0]);
        chk("done_guess", cur_guess, pack(W, m_guess));
        ack_game();

        // randomized games
        for (int g = 0; g < 3; g++) begin
            rand_word(w);
            start_game(w);
            while (!m_win && m_gnum < MG) begin
                for (int k = 0; k < 10; k++) begin
                    logic [3:0] b = 4'($urandom);
                    press(b[0], b[1], b[2], b[3], 0);
                end
                if ($urandom_range(3, 0) == 0) w = m_tgt;
                else rand_word(w);
                enter_word(w);
                submit(1'b0);
            end
            ack_game();
        end

        // reset in the middle of scoring
        rand_word(w);
        start_game(w);
        rand_miss(w);
        enter_word(w);
        submit(1'b0);
        rand_miss(w);
        enter_word(w);
        press(0, 0, 0, 0, 1);
        tick(); tick(); tick();
        reset = 1'b1;
        #1;
        chk_state("midscore_reset_state", 4'b1000);
        chk("midscore_reset_result", result, 0);
        chk("midscore_reset_gnum", guess_num, 0);
        chk("midscore_reset_rv", result_valid, 0);
        chk("midscore_reset_guess", cur_guess, 0);
        tick(); tick();
        reset = 1'b0;
        saw_rv = 1'b0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (result_valid) saw_rv = 1'b1;
        end
        chk("no_partial_result", saw_rv, 0);
        chk_state("idle_after_reset", 4'b1000);

        // WORD_LEN=4, MAX_GUESS=3 instance, guessing "AAAA"
        for (int i = 0; i < 8; i++) t4[i] = (i < W4) ? $urandom_range(25, 1) : 0;
        t4[2] = 0;
        target4 = 20'(pack(W4, t4));
        Start4 = 1'b1;
        tick();
        Start4 = 1'b0;
        chk("w4_entry", q_Entry4, 1);
        for (int n = 1; n <= MG4; n++) begin
            submit4(t4, n);
            tick();
            chk("w4_rv_pulse", result_valid4, 0);
        end
        chk("w4_done", q_Done4, 1);
        chk("w4_win", win4, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
